// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller.
// Holds the cipher state and the current round key, expands the next round
// key on the fly, and drives an external combinational round core once per
// cycle. Blocks enter through a valid/ready handshake on pt/key and leave
// through a valid/ready handshake on ct; one block takes 12 clocks minimum.

module aes128_iter_ctrl #(
    parameter int NR          = 10,
    parameter bit CLR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy,
    output logic [127:0] core_din,
    output logic [127:0] core_kin,
    output logic         core_sel,
    input  logic [127:0] core_dout
);

    // Only the 10-round AES-128 schedule is implemented.
    if (NR != 10) begin : g_nr_check
        $error("aes128_iter_ctrl: NR must be 10 (AES-128 only)");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    // AES S-box, byte 0 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [127:0]  st_r;
    logic [127:0]  rk_r;
    logic [127:0]  ct_r;
    logic [7:0]    rcon_r;
    logic [3:0]    rnd_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;

    logic [127:0]  nk_s;
    logic [127:0]  core_kin_s;
    logic          core_sel_s;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] idx;
        idx = 8'hff - x;
        return SBOX[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8); carries the rcon sequence through 80 -> 1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key from the current round key and rcon.
    always_comb begin
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        w0   = rk_r[127:96];
        w1   = rk_r[95:64];
        w2   = rk_r[63:32];
        w3   = rk_r[31:0];
        t    = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_r, 24'h000000};
        nk_s = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    end

    // Round core drive: next key and final-round flag only while iterating.
    always_comb begin
        core_kin_s = rk_r;
        core_sel_s = 1'b0;
        if (state_r == S_ROUND) begin
            core_kin_s = nk_s;
            core_sel_s = (rnd_r == NR_L);
        end else begin
            core_kin_s = rk_r;
            core_sel_s = 1'b0;
        end
    end

    // Control FSM and datapath registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            st_r        <= 128'h0;
            rk_r        <= 128'h0;
            ct_r        <= 128'h0;
            rcon_r      <= 8'h01;
            rnd_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        st_r       <= pt ^ key;
                        rk_r       <= key;
                        rcon_r     <= 8'h01;
                        rnd_r      <= 4'd1;
                        state_r    <= S_ROUND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_ROUND: begin
                    st_r   <= core_dout;
                    rk_r   <= nk_s;
                    rcon_r <= xtime(rcon_r);
                    if (rnd_r == NR_L) begin
                        ct_r        <= core_dout;
                        rnd_r       <= 4'd0;
                        state_r     <= S_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        rnd_r       <= rnd_r + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        if (CLR_ON_DONE) begin
                            st_r <= 128'h0;
                            rk_r <= 128'h0;
                            ct_r <= 128'h0;
                        end else begin
                            ct_r <= ct_r;
                        end
                    end else begin
                        state_r     <= S_DONE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    rnd_r       <= 4'd0;
                    rcon_r      <= 8'h01;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign ct        = ct_r;
    assign core_din  = st_r;
    assign core_kin  = core_kin_s;
    assign core_sel  = core_sel_s;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl. Supplies a behavioural AES round
// core (S-box derived from GF(2^8) inversion), drives known-answer vectors
// and checks ct through a scoreboard queue, plus latency, backpressure,
// back-to-back spacing, mid-operation reset and the rcon sequence.

module tb_aes128_iter_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;
    logic         busy;
    logic [127:0] core_din;
    logic [127:0] core_kin;
    logic         core_sel;
    logic [127:0] core_dout;

    aes128_iter_ctrl #(.NR(10), .CLR_ON_DONE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy),
        .core_din  (core_din),
        .core_kin  (core_kin),
        .core_sel  (core_sel),
        .core_dout (core_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference round core ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = a[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c+0] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
                a[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
            end
            for (int i = 0; i < 16; i++) b[i] = a[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    assign core_dout = aes_round(core_din, core_kin, core_sel);

    // ---------------- bench state ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [3];
    logic [7:0]   rcon_exp [10];
    logic [127:0] exp_q [$];
    int           checks;
    int           failures;
    int           cyc;
    bit           acc_flag;
    int           acc_edge;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: scoreboard/accept monitoring just before the edge, then advance.
    task automatic cycle();
        logic [127:0] e;
        acc_flag = 1'b0;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_output actual=%h expected=<none>", ct);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ct", ct, e);
            end
        end
        if (!rst && in_valid && in_ready) begin
            acc_flag = 1'b1;
            acc_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_accept();
        for (int n = 0; n < 30 && !acc_flag; n++) cycle();
        chk("accept_seen", 128'(acc_flag), 128'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) cycle();
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // Full block with out_ready high: latency, ct via scoreboard, clear-on-done.
    task automatic run_block(input int vi);
        int lat;
        pt        = vecs[vi].pt;
        key       = vecs[vi].key;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(vecs[vi].ct);
        cycle();
        if (!acc_flag) wait_accept();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) cycle();
        lat = cyc - acc_edge;
        chk("latency", 128'(lat), 128'd10);
        cycle();
        chk("post_done_in_ready", 128'(in_ready), 128'd1);
        chk("post_done_ct_clear", ct, 128'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]   inv;
        logic [7:0]   bb;
        logic [127:0] prev;
        logic [7:0]   rc;
        int           acc_t [3];
        int           h;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        acc_flag = 1'b0;
        acc_edge = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt        = 128'h0;
        key       = 128'h0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            bb = inv;
            sbox_t[x] = bb ^ rotl1(bb) ^ rotl1(rotl1(bb)) ^ rotl1(rotl1(rotl1(bb)))
                        ^ rotl1(rotl1(rotl1(rotl1(bb)))) ^ 8'h63;
        end

        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h00000000000000000000000000000000,
                    pt:  128'h00000000000000000000000000000000,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        // Reset state
        cycle();
        cycle();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ct", ct, 128'h0);
        chk("rst_core_din", core_din, 128'h0);
        chk("rst_core_sel", 128'(core_sel), 128'd0);
        rst = 1'b0;
        cycle();

        // Known-answer table
        for (int v = 0; v < 3; v++) run_block(v);

        // Round-by-round key monitoring on the C.1 vector
        pt        = vecs[1].pt;
        key       = vecs[1].key;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(vecs[1].ct);
        wait_accept();
        in_valid = 1'b0;
        prev     = vecs[1].key;
        for (int r = 1; r <= 10; r++) begin
            rc = core_kin[127:120] ^ prev[127:120] ^ sbox_t[prev[23:16]];
            chk($sformatf("rcon_round%0d", r), 128'(rc), 128'(rcon_exp[r-1]));
            chk($sformatf("core_sel_round%0d", r), 128'(core_sel), 128'(r == 10));
            chk($sformatf("busy_round%0d", r), 128'(busy), 128'd1);
            if (r == 10) chk("kin_round10", core_kin, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            prev = core_kin;
            cycle();
        end
        chk("c1_out_valid", 128'(out_valid), 128'd1);
        drain();

        // Backpressure with a concurrent, ignored in_valid
        out_ready = 1'b0;
        pt        = vecs[0].pt;
        key       = vecs[0].key;
        in_valid  = 1'b1;
        exp_q.push_back(vecs[0].ct);
        wait_accept();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) cycle();
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin
                pt       = vecs[2].pt;
                key      = vecs[2].key;
                in_valid = 1'b1;
                exp_q.push_back(vecs[2].ct);
            end
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_ct_hold", ct, vecs[0].ct);
            cycle();
            chk("bp_no_accept", 128'(acc_flag), 128'd0);
        end
        out_ready = 1'b1;
        cycle();
        h = cyc;
        chk("hs_in_ready", 128'(in_ready), 128'd1);
        chk("hs_out_valid", 128'(out_valid), 128'd0);
        chk("hs_ct_clear", ct, 128'h0);
        cycle();
        chk("bp_next_accept", 128'(acc_flag), 128'd1);
        chk("bp_next_accept_edge", 128'(acc_edge - h), 128'd1);
        in_valid = 1'b0;
        drain();

        // Back-to-back with in_valid and out_ready tied high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            pt  = vecs[b].pt;
            key = vecs[b].key;
            exp_q.push_back(vecs[b].ct);
            acc_flag = 1'b0;
            cycle();
            if (!acc_flag) wait_accept();
            acc_t[b] = acc_edge;
        end
        in_valid = 1'b0;
        drain();
        chk("b2b_gap01", 128'(acc_t[1] - acc_t[0]), 128'd12);
        chk("b2b_gap12", 128'(acc_t[2] - acc_t[1]), 128'd12);

        // Reset in round 5
        pt       = vecs[1].pt;
        key      = vecs[1].key;
        in_valid = 1'b1;
        exp_q.push_back(vecs[1].ct);
        wait_accept();
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) cycle();
        chk("midrst_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        cycle();
        exp_q.delete();
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_ct", ct, 128'h0);
        rst = 1'b0;
        cycle();
        chk("midrst_no_output", 128'(out_valid), 128'd0);
        run_block(0);

        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
